// File: rtl/pkmc_sdram_sched.sv
// rtl/pkmc_sdram_sched.sv - two-requester arbiter and refresh scheduler for the PKMC SDRAM controller
module pkmc_sdram_sched #(
  parameter int REF_PERIOD   = 390,
  parameter int REF_MAX_PEND = 4,
  parameter int CNT_W        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic       m1_req,
  input  logic       m1_we,
  output logic       m0_gnt,
  output logic       m1_gnt,
  output logic       ctrl_active,
  output logic       ctrl_we,
  output logic       ctrl_sel,
  input  logic       ctrl_done,
  output logic       auto_ref,
  input  logic       ref_irq,
  output logic       ref_ack,
  output logic [2:0] ref_pend
);

  typedef enum logic [1:0] {IDLE, G0, G1, REF} state_t;

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(REF_PERIOD - 1);
  localparam logic [2:0]       PEND_MAX = 3'(REF_MAX_PEND);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             ref_done;
  logic             rr, rr_n;
  logic             m0_gnt_n, m1_gnt_n, active_n, we_n, sel_n, auto_ref_n, ref_ack_n;

  // The timer only counts once the controller is out of its init sequence.
  assign tick     = init_done && (cnt == '0);
  // A refresh completes on the cycle the controller is seen parked in ackWait.
  assign ref_done = (state == REF) && ref_irq;

  // Refresh interval counter: counts down, reloads on expiry or while init is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= RELOAD;
    else if (!init_done || cnt == '0)
      cnt <= RELOAD;
    else
      cnt <= cnt - 1'b1;
  end

  // Refresh debt: ticks add, completions subtract, a coincident pair cancels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ref_pend <= '0;
    else if (tick && !ref_done && ref_pend != PEND_MAX)
      ref_pend <= ref_pend + 1'b1;
    else if (ref_done && !tick)
      ref_pend <= ref_pend - 1'b1;
  end

  // State, round-robin pointer and all controller-facing outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr          <= 1'b0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      ctrl_active <= 1'b0;
      ctrl_we     <= 1'b0;
      ctrl_sel    <= 1'b0;
      auto_ref    <= 1'b0;
      ref_ack     <= 1'b0;
    end else begin
      state       <= state_n;
      rr          <= rr_n;
      m0_gnt      <= m0_gnt_n;
      m1_gnt      <= m1_gnt_n;
      ctrl_active <= active_n;
      ctrl_we     <= we_n;
      ctrl_sel    <= sel_n;
      auto_ref    <= auto_ref_n;
      ref_ack     <= ref_ack_n;
    end
  end

  // Next-state arbitration and the output values that go with the next state.
  always_comb begin
    state_n    = state;
    rr_n       = rr;
    m0_gnt_n   = 1'b0;
    m1_gnt_n   = 1'b0;
    active_n   = 1'b0;
    we_n       = 1'b0;
    sel_n      = ctrl_sel;
    auto_ref_n = 1'b0;
    ref_ack_n  = 1'b0;

    case (state)
      IDLE: begin
        if (init_done) begin
          // Refresh wins when urgent, or opportunistically when nobody wants the bus.
          if (ref_pend == PEND_MAX || (ref_pend != '0 && !m0_req && !m1_req)) begin
            state_n = REF;
          end else if (m0_req && m1_req) begin
            state_n = rr ? G1 : G0;
            rr_n    = ~rr;
          end else if (m0_req) begin
            state_n = G0;
          end else if (m1_req) begin
            state_n = G1;
          end
        end
      end
      G0, G1: begin
        // Grants are never preempted; always pass through IDLE afterwards.
        if (ctrl_done)
          state_n = IDLE;
      end
      REF: begin
        if (ref_irq) begin
          state_n   = IDLE;
          ref_ack_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      G0: begin
        m0_gnt_n = 1'b1;
        active_n = 1'b1;
        sel_n    = 1'b0;
        we_n     = m0_we;
      end
      G1: begin
        m1_gnt_n = 1'b1;
        active_n = 1'b1;
        sel_n    = 1'b1;
        we_n     = m1_we;
      end
      REF:     auto_ref_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pkmc_sdram_sched.sv
// tb/tb_pkmc_sdram_sched.sv - directed self-checking bench for pkmc_sdram_sched
module tb_pkmc_sdram_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done, m0_req, m0_we, m1_req, m1_we, ctrl_done, ref_irq;
  logic       m0_gnt, m1_gnt, ctrl_active, ctrl_we, ctrl_sel, auto_ref, ref_ack;
  logic [2:0] ref_pend;
  logic [9:0] outs;

  int n_asrt = 0;
  int n_fail = 0;

  pkmc_sdram_sched #(.REF_PERIOD(8), .REF_MAX_PEND(4), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .m0_req(m0_req), .m0_we(m0_we), .m1_req(m1_req), .m1_we(m1_we),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .ctrl_active(ctrl_active),
    .ctrl_we(ctrl_we), .ctrl_sel(ctrl_sel), .ctrl_done(ctrl_done),
    .auto_ref(auto_ref), .ref_irq(ref_irq), .ref_ack(ref_ack), .ref_pend(ref_pend)
  );

  assign outs = {m0_gnt, m1_gnt, ctrl_active, ctrl_we, ctrl_sel, auto_ref, ref_ack, ref_pend};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Holds reset across two rising edges with all inputs idle, releases on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    init_done = 1'b0; m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    ctrl_done = 1'b0; ref_irq = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // T1: reset values, async reset mid-G1, first grant after release goes to m0
    rst = 1'b1;
    init_done = 1'b0; m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    ctrl_done = 1'b0; ref_irq = 1'b0;
    step();
    step();
    chk("reset_outs", 16'(outs), 16'd0);
    rst = 1'b0; init_done = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    step();
    chk("t1_m1_gnt", 16'(m1_gnt), 16'd1);
    chk("t1_m0_gnt", 16'(m0_gnt), 16'd0);
    chk("t1_active", 16'(ctrl_active), 16'd1);
    chk("t1_sel", 16'(ctrl_sel), 16'd1);
    chk("t1_we", 16'(ctrl_we), 16'd1);
    #2 rst = 1'b1;
    #1 chk("t1_async_rst_outs", 16'(outs), 16'd0);
    step();
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b1;

    // T2: both requesting, done 3 cycles after each grant -> m0,m1,m0,m1
    for (int g = 0; g < 4; g++) begin
      logic w;
      w = 1'(g % 2);
      step();
      chk($sformatf("t2_m0_gnt_%0d", g), 16'(m0_gnt), 16'(!w));
      chk($sformatf("t2_m1_gnt_%0d", g), 16'(m1_gnt), 16'(w));
      chk($sformatf("t2_sel_%0d", g), 16'(ctrl_sel), 16'(w));
      chk($sformatf("t2_we_%0d", g), 16'(ctrl_we), 16'(w));
      chk($sformatf("t2_active_%0d", g), 16'(ctrl_active), 16'd1);
      step();
      step();
      chk($sformatf("t2_held_%0d", g), 16'(m0_gnt | m1_gnt), 16'd1);
      ctrl_done = 1'b1;
      step();
      ctrl_done = 1'b0;
      chk($sformatf("t2_gap_%0d", g), 16'({m0_gnt, m1_gnt, ctrl_active}), 16'd0);
      chk($sformatf("t2_sel_hold_%0d", g), 16'(ctrl_sel), 16'(w));
    end
    chk("t2_pend", 16'(ref_pend), 16'd2);

    // T3: idle refresh with REF_PERIOD=8
    do_reset();
    init_done = 1'b1;
    repeat (7) step();
    chk("t3_pend_c7", 16'(ref_pend), 16'd0);
    step();
    chk("t3_pend_c8", 16'(ref_pend), 16'd1);
    chk("t3_autoref_c8", 16'(auto_ref), 16'd0);
    step();
    chk("t3_autoref_c9", 16'(auto_ref), 16'd1);
    chk("t3_active_c9", 16'(ctrl_active), 16'd0);
    chk("t3_ack_c9", 16'(ref_ack), 16'd0);
    step();
    chk("t3_autoref_c10", 16'(auto_ref), 16'd1);
    chk("t3_ack_c10", 16'(ref_ack), 16'd0);
    ref_irq = 1'b1;
    step();
    chk("t3_ack_c11", 16'(ref_ack), 16'd1);
    chk("t3_autoref_c11", 16'(auto_ref), 16'd0);
    chk("t3_pend_c11", 16'(ref_pend), 16'd0);
    ref_irq = 1'b0;
    step();
    chk("t3_ack_c12", 16'(ref_ack), 16'd0);

    // T5: tick at cycle 24 coincides with the refresh completion
    repeat (4) step();
    chk("t5_pend_c16", 16'(ref_pend), 16'd1);
    step();
    chk("t5_autoref_c17", 16'(auto_ref), 16'd1);
    repeat (6) step();
    chk("t5_pend_c23", 16'(ref_pend), 16'd1);
    ref_irq = 1'b1;
    step();
    chk("t5_ack_c24", 16'(ref_ack), 16'd1);
    chk("t5_pend_c24", 16'(ref_pend), 16'd1);
    chk("t5_autoref_c24", 16'(auto_ref), 16'd0);
    ref_irq = 1'b0;
    step();
    chk("t5_autoref_c25", 16'(auto_ref), 16'd1);
    chk("t5_ack_c25", 16'(ref_ack), 16'd0);

    // T4: m0 holds the bus 40 cycles (7..47); debt saturates, urgent refresh beats m1
    do_reset();
    init_done = 1'b1;
    repeat (6) step();
    m0_req = 1'b1; m0_we = 1'b1;
    step();
    chk("t4_m0_gnt_c7", 16'(m0_gnt), 16'd1);
    chk("t4_we_c7", 16'(ctrl_we), 16'd1);
    repeat (13) step();
    m1_req = 1'b1;
    repeat (13) step();
    chk("t4_pend_c33", 16'(ref_pend), 16'd4);
    chk("t4_m0_hold_c33", 16'(m0_gnt), 16'd1);
    repeat (7) step();
    chk("t4_pend_sat_c40", 16'(ref_pend), 16'd4);
    chk("t4_autoref_c40", 16'(auto_ref), 16'd0);
    repeat (6) step();
    ctrl_done = 1'b1;
    step();
    chk("t4_gnt_drop_c47", 16'({m0_gnt, m1_gnt}), 16'd0);
    chk("t4_pend_c47", 16'(ref_pend), 16'd4);
    ctrl_done = 1'b0; m0_req = 1'b0;
    step();
    chk("t4_autoref_c48", 16'(auto_ref), 16'd1);
    chk("t4_m1_gnt_c48", 16'(m1_gnt), 16'd0);
    chk("t4_active_c48", 16'(ctrl_active), 16'd0);
    chk("t4_pend_c48", 16'(ref_pend), 16'd4);
    m1_req = 1'b0; ref_irq = 1'b1;
    for (int h = 1; h <= 4; h++) begin
      step();
      chk($sformatf("t4_ack_%0d", h), 16'(ref_ack), 16'd1);
      chk($sformatf("t4_autoref_ack_%0d", h), 16'(auto_ref), 16'd0);
      chk($sformatf("t4_pend_%0d", h), 16'(ref_pend), 16'(4 - h));
      if (h == 4) ref_irq = 1'b0;
      step();
      chk($sformatf("t4_ack_low_%0d", h), 16'(ref_ack), 16'd0);
      chk($sformatf("t4_autoref_next_%0d", h), 16'(auto_ref), 16'(h < 4));
    end
    chk("t4_pend_c56", 16'(ref_pend), 16'd1);

    // T6: init_done=0 blocks grants, refresh and the timer
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      chk($sformatf("t6_gated_%0d", c), 16'({m0_gnt, m1_gnt, auto_ref, ref_pend}), 16'd0);
    end
    init_done = 1'b1;
    step();
    chk("t6_first_gnt_m0", 16'(m0_gnt), 16'd1);
    chk("t6_first_gnt_m1", 16'(m1_gnt), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
